// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipeline MEM stage.
//
// Holds a word-organised RAM (2^(ADDR_W-2) words) and serves one RV32I
// load or store at a time. Each access takes WAIT_CYCLES extra cycles
// between request accept and response. Stores write through byte lanes.
// Loads are sign- or zero-extended according to funct3.
//
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a
// misaligned half or word access does not touch RAM and responds with
// rsp_err=1 and rsp_rdata=0. When it is undefined, the low address bits
// are truncated and rsp_err stays 0.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   reset      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder idle and able to accept a request
//   req_write  in   1 = store, 0 = load
//   req_funct3 in   RV32I funct3 of the access
//   req_addr   in   byte address (ADDR_W bits)
//   req_wdata  in   right-aligned store data
//   rsp_valid  out  response present, held until rsp_ready
//   rsp_ready  in   pipeline accepts the response
//   rsp_rdata  out  extended load data; 0 for stores
//   rsp_err    out  misaligned-access flag
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic accept, commit;

  logic              cap_write;
  logic [2:0]        cap_funct3;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              op_write;
  logic [2:0]        op_funct3;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;

  logic [ADDR_W-3:0] widx;
  logic [1:0]        lane;
  logic              misaligned;
  logic [3:0]        store_be;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane enables for a store of the given width at the given lane.
  function automatic logic [3:0] lane_en(input logic [2:0] f3, input logic [1:0] ln);
    case (f3)
      3'b000:  lane_en = 4'b0001 << ln;
      3'b001:  lane_en = ln[1] ? 4'b1100 : 4'b0011;
      3'b010:  lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  // Replicate the right-aligned store data across every lane so the
  // enables alone pick the destination bytes.
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  lane_data = {4{wd[7:0]}};
      3'b001:  lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  // Select the addressed byte/half and extend it to a full word.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] word,
                                           input logic [1:0] ln);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[8*ln +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = b;
      3'b001:  r = h;
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = '0;
    endcase
    load_ext = r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic mis_check(input logic wr, input logic [2:0] f3, input logic [1:0] ln);
    logic half, word;
    half = (f3 == 3'b001) || (!wr && f3 == 3'b101);
    word = (f3 == 3'b010);
    mis_check = (half && ln[0]) || (word && ln != 2'b00);
  endfunction
`endif

  // With WAIT_CYCLES=0 the commit happens on the accept edge itself, so
  // the live request fields are used; otherwise the captured copy.
  always_comb begin
    if (state == S_IDLE) begin
      op_write  = req_write;
      op_funct3 = req_funct3;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
    end else begin
      op_write  = cap_write;
      op_funct3 = cap_funct3;
      op_addr   = cap_addr;
      op_wdata  = cap_wdata;
    end
  end

  assign widx = op_addr[ADDR_W-1:2];
  assign lane = op_addr[1:0];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = mis_check(op_write, op_funct3, lane);
`else
  assign misaligned = 1'b0;
`endif

  assign rd_word    = mem[widx];
  assign store_data = lane_data(op_funct3, op_wdata);
  // Gating with reset keeps a store from landing while reset is held.
  assign store_be   = (commit && op_write && !misaligned && reset)
                      ? lane_en(op_funct3, lane) : 4'b0000;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = S_RESP;
            commit    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        rsp_err   <= misaligned;
        rsp_rdata <= (op_write || misaligned) ? '0 : load_ext(op_funct3, rd_word, lane);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write  <= req_write;
      cap_funct3 <= req_funct3;
      cap_addr   <= req_addr;
      cap_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (store_be[b]) mem[widx][8*b +: 8] <= store_data[8*b +: 8];
    end
  end

endmodule
